apb_master: RTL
===============

Name: apb_master

Overview:
- APB requester for the local APB bus; the initiating end of the bus that the APB slave/memory bridges respond to.
- Accepts single read/write commands from a host-side valid/ready port, e.g. the I2C controller or a test sequencer.
- Drives the SETUP and ACCESS phases with encoded slave select and wait-cycle hint, waits for ready, and returns one response per command.
- Includes an ACCESS-phase timeout so a silent slave cannot hang the bus.

Parameters:
- ADDR_W, 8, width of cmd_addr/apb_addr
- DATA_W, 8, width of write/read data
- TIMEOUT, 255, max ACCESS cycles without apb_ready before abort (1..255)

Ports:
- clk  in  1  bus clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  master can accept a command
- cmd_write  in  1  1=write, 0=read
- cmd_id  in  2  target slave id 1..3; 0 is reserved/illegal
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- cmd_wait  in  8  wait-cycle hint forwarded to slave
- rsp_valid  out  1  one-cycle response strobe
- rsp_rdata  out  DATA_W  read data (0 for writes/errors)
- rsp_err  out  1  response is an error (illegal id or timeout)
- apb_sel  out  2  encoded select; 0 = no slave selected
- apb_enable  out  1  ACCESS phase indicator
- apb_write  out  1  transfer direction
- apb_addr  out  ADDR_W  transfer address
- apb_wdata  out  DATA_W  transfer write data
- apb_wait_cycles  out  8  wait hint for selected slave
- apb_rdata  in  DATA_W  slave read data
- apb_ready  in  1  slave transfer complete

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0, including cmd_ready, rsp_*, apb_*; timeout counter 0. Takes effect immediately, including mid-transfer; bus is released with no response.
- Outputs are registered, except cmd_ready = (state==IDLE) && reset deasserted.
- Handshake: command accepted on a rising edge with cmd_valid && cmd_ready. All cmd_* fields are captured then; host may change them afterwards.
- IDLE: cmd_ready=1.
  - Accept with cmd_id!=0 -> SETUP.
  - Accept with cmd_id==0 -> ERR. No bus activity.
- SETUP (exactly 1 cycle): apb_sel=cmd_id, apb_write, apb_addr, apb_wdata, apb_wait_cycles driven from the captured command; apb_enable=0 -> ACCESS.
- ACCESS: apb_enable=1; all apb_* fields held stable. apb_ready is sampled each rising edge.
  - Ready=1 -> RESP: capture apb_rdata if read, else 0; err=0.
  - Ready=0 -> increment counter. When counter reaches TIMEOUT-1 with ready still 0 -> RESP with err=1, rdata=0.
- RESP/ERR (1 cycle): rsp_valid=1 with rsp_rdata/rsp_err.
  - apb_sel=0, apb_enable=0, apb_write/addr/wdata/wait_cycles return to 0.
  - Counter cleared -> IDLE.
- ERR cycle: rsp_err=1, rsp_rdata=0.
- rsp_valid is a single-cycle strobe; there is no backpressure on the response, and the host must take it.
- Latency, command accepted at edge N:
  - SETUP in cycle N+1, ACCESS from N+2.
  - Zero-wait slave: rsp_valid in cycle N+3, cmd_ready high in N+4.
  - Each extra ACCESS cycle adds 1.
  - Minimum 4 cycles per transfer; back-to-back commands are accepted on each IDLE.
- Timeout: the ACCESS phase lasts at most TIMEOUT cycles.
- apb_ready outside ACCESS is ignored.
- apb_wait_cycles is informational; completion is decided only by apb_ready.

Test Plan:
- Write: cmd id=1, addr=8'h10, wdata=8'hA5, wait=0; slave ready in first ACCESS cycle -> SETUP shows sel=1, write=1, enable=0; then ACCESS enable=1; rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read with waits: id=2, addr=8'h22, wait=3; ready after 3 ACCESS cycles with rdata=8'h5C -> apb_* stable for all ACCESS cycles; rsp_rdata=8'h5C; total latency 6 cycles.
- Timeout (TIMEOUT=4): read id=3, ready held 0 -> exactly 4 ACCESS cycles, then rsp_valid with rsp_err=1, rsp_rdata=0; bus returns to sel=0.
- Illegal id: cmd id=0 -> apb_sel never leaves 0; rsp_valid+rsp_err=1 the cycle after accept.
- Reset mid-ACCESS: assert reset during ACCESS -> all outputs 0 asynchronously with no rsp_valid; after release, cmd_ready=1 and a new write completes normally.
- Back-to-back: cmd_valid held high with 3 queued writes -> each accepted in IDLE; one rsp_valid per command; no overlap of SETUP with previous ACCESS.

Source files
------------

// File: rtl/apb_master.sv
// APB requester: takes single read/write commands from a host valid/ready
// port and runs one SETUP/ACCESS transfer per command, with an ACCESS timeout.
//
// Ports:
//   clk, reset        bus clock, asynchronous active-low reset
//   cmd_*             host command port (valid/ready, write, id, addr, wdata, wait)
//   rsp_*             one-cycle response strobe with read data and error flag
//   apb_*             APB requester side (encoded select, enable, direction,
//                     address, write data, wait hint, read data, ready)
module apb_master #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [1:0]        cmd_id,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   input  logic [7:0]        cmd_wait,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [1:0]        apb_sel,
   output logic              apb_enable,
   output logic              apb_write,
   output logic [ADDR_W-1:0] apb_addr,
   output logic [DATA_W-1:0] apb_wdata,
   output logic [7:0]        apb_wait_cycles,
   input  logic [DATA_W-1:0] apb_rdata,
   input  logic              apb_ready
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_RESP,
      S_ERR
   } state_t;

   // Last ACCESS count value before the transfer is abandoned.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t            state;
   state_t            state_n;
   logic [7:0]        cnt;
   logic [7:0]        cnt_n;

   logic [1:0]        sel_n;
   logic              enable_n;
   logic              write_n;
   logic [ADDR_W-1:0] addr_n;
   logic [DATA_W-1:0] wdata_n;
   logic [7:0]        wait_n;
   logic              rsp_valid_n;
   logic [DATA_W-1:0] rsp_rdata_n;
   logic              rsp_err_n;

   assign cmd_ready = (state == S_IDLE) && reset;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= S_IDLE;
         cnt             <= '0;
         apb_sel         <= '0;
         apb_enable      <= 1'b0;
         apb_write       <= 1'b0;
         apb_addr        <= '0;
         apb_wdata       <= '0;
         apb_wait_cycles <= '0;
         rsp_valid       <= 1'b0;
         rsp_rdata       <= '0;
         rsp_err         <= 1'b0;
      end else begin
         state           <= state_n;
         cnt             <= cnt_n;
         apb_sel         <= sel_n;
         apb_enable      <= enable_n;
         apb_write       <= write_n;
         apb_addr        <= addr_n;
         apb_wdata       <= wdata_n;
         apb_wait_cycles <= wait_n;
         rsp_valid       <= rsp_valid_n;
         rsp_rdata       <= rsp_rdata_n;
         rsp_err         <= rsp_err_n;
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      sel_n       = apb_sel;
      enable_n    = apb_enable;
      write_n     = apb_write;
      addr_n      = apb_addr;
      wdata_n     = apb_wdata;
      wait_n      = apb_wait_cycles;
      rsp_valid_n = 1'b0;
      rsp_rdata_n = '0;
      rsp_err_n   = 1'b0;

      unique case (state)
         S_IDLE: begin
            cnt_n = '0;
            if (cmd_valid && cmd_ready) begin
               if (cmd_id != 2'd0) begin
                  // The bus registers double as the command capture.
                  state_n  = S_SETUP;
                  sel_n    = cmd_id;
                  enable_n = 1'b0;
                  write_n  = cmd_write;
                  addr_n   = cmd_addr;
                  wdata_n  = cmd_wdata;
                  wait_n   = cmd_wait;
               end else begin
                  // Reserved id: answer with an error, never touch the bus.
                  state_n     = S_ERR;
                  rsp_valid_n = 1'b1;
                  rsp_err_n   = 1'b1;
               end
            end
         end

         S_SETUP: begin
            state_n  = S_ACCESS;
            enable_n = 1'b1;
            cnt_n    = '0;
         end

         S_ACCESS: begin
            if (apb_ready || (cnt == CNT_LAST)) begin
               state_n     = S_RESP;
               rsp_valid_n = 1'b1;
               rsp_err_n   = !apb_ready;
               if (apb_ready && !apb_write) begin
                  rsp_rdata_n = apb_rdata;
               end
               cnt_n    = '0;
               sel_n    = '0;
               enable_n = 1'b0;
               write_n  = 1'b0;
               addr_n   = '0;
               wdata_n  = '0;
               wait_n   = '0;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end

         S_RESP, S_ERR: begin
            state_n = S_IDLE;
            cnt_n   = '0;
         end

         default: begin
            state_n  = S_IDLE;
            cnt_n    = '0;
            sel_n    = '0;
            enable_n = 1'b0;
            write_n  = 1'b0;
            addr_n   = '0;
            wdata_n  = '0;
            wait_n   = '0;
         end
      endcase
   end

endmodule
